// File: rtl/pulse_meas_module.sv
// pulse_meas_module: measures period and high time of an asynchronous pulse train in CLK cycles.
module pulse_meas_module #(
  parameter int CNT_W = 23,
  parameter logic [CNT_W-1:0] T_TIMEOUT = 23'd5_000_000
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Pulse_In,
  output logic [CNT_W-1:0] Period_Out,
  output logic [CNT_W-1:0] High_Out,
  output logic             Meas_Valid,
  output logic             Timeout_Flag,
  output logic             Level_Out
);
  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;
  state_t state_q;
  logic s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, high_hold_q, period_q, high_q;
  logic valid_q, timeout_q;
  logic rise, fall, expired;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;
  assign expired = cnt_q == T_TIMEOUT;
  assign Period_Out = period_q;
  assign High_Out = high_q;
  assign Meas_Valid = valid_q;
  assign Timeout_Flag = timeout_q;
  assign Level_Out = s2_q;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      {s1_q, s2_q, s3_q} <= '0;
      cnt_q <= '0;
      high_hold_q <= '0;
      period_q <= '0;
      high_q <= '0;
      valid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s1_q <= Pulse_In;
      s2_q <= s1_q;
      s3_q <= s2_q;
      valid_q <= 1'b0;
      cnt_q <= rise ? CNT_W'(1) : (state_q == IDLE ? '0 : cnt_q + 1'b1);
      // Edges take priority over an expiring count in both measuring states.
      case (state_q)
        IDLE: if (rise) state_q <= MEAS_HIGH;
        MEAS_HIGH:
          if (fall) begin
            high_hold_q <= cnt_q;
            state_q <= MEAS_LOW;
          end else if (expired) begin
            timeout_q <= 1'b1;
            state_q <= IDLE;
          end
        MEAS_LOW:
          if (rise) begin
            period_q <= cnt_q;
            high_q <= high_hold_q;
            valid_q <= 1'b1;
            timeout_q <= 1'b0;
            state_q <= MEAS_HIGH;
          end else if (expired) begin
            timeout_q <= 1'b1;
            state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
